ahb_latency_ram: RTL and testbench

AHB-Lite subordinate RAM. It is the responder end of the AHB interface the core's bus interface unit drives as initiator. Wait states are programmable (RAM_LATENCY) to stress initiator stall handling, and burst beats can optionally be accelerated (BURST_EN). It sits in the uncore behind the address decoder, as the UNCORE_RAM target.

---
 rtl/ahb_latency_ram_pkg.sv | 20 ++
 rtl/ahb_latency_ram_ram_bytewrite.sv | 28 ++
 rtl/ahb_latency_ram.sv | 150 +++++++++++++++
 tb/tb_ahb_latency_ram.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_latency_ram_pkg.sv
// Shared AHB-Lite encodings and the FSM state type for the latency RAM.
package ahb_latency_ram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/ahb_latency_ram_ram_bytewrite.sv
// Byte-enabled single-port array: asynchronous read, synchronous byte-masked write.
// Latency: read 0 cycles, write commits at the clock edge. No backpressure.
module ram_bytewrite #(
  parameter int DW    = 64,
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [DW/8-1:0] wstrb,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DW/8; i++) begin
        if (wstrb[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_latency_ram.sv
// AHB-Lite subordinate RAM with RAM_LATENCY wait states per beat; SEQ beats skip them when BURST_EN.
// Latency: RAM_LATENCY+1 cycles per NONSEQ beat. Backpressure: HREADYRam low during waits.
// RAM_ERROR_RESP_EN: out-of-range accesses get a two-cycle ERROR instead of aliasing.
module ahb_latency_ram
  import ahb_latency_ram_pkg::*;
#(
  parameter int          AHBW        = 64,
  parameter int          PA_BITS     = 56,
  parameter logic [63:0] RANGE       = 64'h0FFF,
  parameter int          RAM_LATENCY = 0,
  parameter bit          BURST_EN    = 1'b1
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSELRam,
  input  logic [PA_BITS-1:0] HADDR,
  input  logic               HWRITE,
  input  logic [1:0]         HTRANS,
  input  logic [2:0]         HSIZE,
  input  logic [2:0]         HBURST,
  input  logic               HREADY,
  input  logic [AHBW-1:0]    HWDATA,
  input  logic [AHBW/8-1:0]  HWSTRB,
  output logic               HREADYRam,
  output logic               HRESPRam,
  output logic [AHBW-1:0]    HREADRam
);

  localparam int BYTES = AHBW / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int DEPTH = int'((RANGE + 64'd1) / 64'(BYTES));
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_M1 = (RAM_LATENCY == 0) ? 4'd0 : 4'(RAM_LATENCY - 1);

  state_t          state;
  logic [3:0]      cnt;
  logic [AW-1:0]   addr_q;
  logic            write_q;
  logic            ready_q;
  logic            resp_q;
  logic            accept;
  logic            zero_lat;
  logic            ram_we;
  logic [AW-1:0]   addr_idx;
  logic [AHBW-1:0] rdata;
  logic            unused_ok;

  assign accept   = HSELRam & HREADY & HTRANS[1];
  assign zero_lat = (RAM_LATENCY == 0) || (BURST_EN && (HTRANS == HTRANS_SEQ));
  // Word index wraps modulo depth because only the low AW word bits are kept.
  assign addr_idx = HADDR[OFFS +: AW];

`ifdef RAM_ERROR_RESP_EN
  localparam logic [PA_BITS-1:0] RANGE_PA = RANGE[PA_BITS-1:0];
  logic err_q;
  logic addr_err;
  assign addr_err = HADDR > RANGE_PA;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      ready_q <= 1'b1;
      resp_q  <= HRESP_OKAY;
`ifdef RAM_ERROR_RESP_EN
      err_q   <= 1'b0;
`endif
    end else if (accept) begin
      // A pipelined address phase is only possible while HREADY is high,
      // i.e. in IDLE, DATA or ERR2, so it can take priority over the state.
      addr_q  <= addr_idx;
      write_q <= HWRITE;
`ifdef RAM_ERROR_RESP_EN
      err_q   <= addr_err;
`endif
      if (!zero_lat) begin
        state   <= ST_WAIT;
        cnt     <= LAT_M1;
        ready_q <= 1'b0;
        resp_q  <= HRESP_OKAY;
      end
`ifdef RAM_ERROR_RESP_EN
      else if (addr_err) begin
        state   <= ST_ERR1;
        ready_q <= 1'b0;
        resp_q  <= HRESP_ERROR;
      end
`endif
      else begin
        state   <= ST_DATA;
        ready_q <= 1'b1;
        resp_q  <= HRESP_OKAY;
      end
    end else begin
      case (state)
        ST_WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
`ifdef RAM_ERROR_RESP_EN
          else if (err_q) begin
            state   <= ST_ERR1;
            ready_q <= 1'b0;
            resp_q  <= HRESP_ERROR;
          end
`endif
          else begin
            state   <= ST_DATA;
            ready_q <= 1'b1;
          end
        end
`ifdef RAM_ERROR_RESP_EN
        ST_ERR1: begin
          state   <= ST_ERR2;
          ready_q <= 1'b1;
          resp_q  <= HRESP_ERROR;
        end
`endif
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          resp_q  <= HRESP_OKAY;
        end
      endcase
    end
  end

  assign ram_we = (state == ST_DATA) && ready_q && write_q;

  ram_bytewrite #(
    .DW    (AHBW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (HCLK),
    .we    (ram_we),
    .addr  (addr_q),
    .wstrb (HWSTRB),
    .wdata (HWDATA),
    .rdata (rdata)
  );

  assign HREADYRam = ready_q;
  assign HRESPRam  = resp_q;
  assign HREADRam  = (state == ST_DATA) ? rdata : '0;

  assign unused_ok = ^{HSIZE, HBURST, HADDR};

endmodule

// File: tb/tb_ahb_latency_ram.sv
// Bench for ahb_latency_ram: three instances (latency 0; latency 3 with/without burst
// acceleration) share one AHB master and are checked against a word-array model.
module tb_ahb_latency_ram;
  import ahb_latency_ram_pkg::*;

  localparam int NI    = 3;
  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  sel;
  logic [55:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hready;
  logic [63:0] hwdata;
  logic [7:0]  hwstrb;
  logic [2:0]  rdy;
  logic [2:0]  resp;
  logic [63:0] rdat [NI];
  int          cur = 0;

  int n_cmp = 0;
  int n_bad = 0;

  // Beat description for one run, and what came back.
  logic [55:0] x_addr  [16];
  bit          x_wr    [16];
  bit          x_seq   [16];
  logic [63:0] x_wdata [16];
  logic [7:0]  x_strb  [16];
  int          g_waits [16];
  logic [63:0] g_rd    [16];
  bit          g_resp  [16];
  bit          g_errlow[16];

  // Reference model: per-instance word arrays with per-byte known flags.
  logic [63:0] mdl [NI][DEPTH];
  bit   [7:0]  mbv [NI][DEPTH];
  logic [63:0] e_rd   [16];
  logic [63:0] e_mask [16];
  int          e_waits[16];

  always #5 clk = ~clk;
  assign hready = rdy[cur];

  ahb_latency_ram #(.RAM_LATENCY(0), .BURST_EN(1'b1)) u_lat0 (
    .HCLK(clk), .HRESETn(rst_n), .HSELRam(sel[0]), .HADDR(haddr), .HWRITE(hwrite),
    .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HREADY(hready), .HWDATA(hwdata),
    .HWSTRB(hwstrb), .HREADYRam(rdy[0]), .HRESPRam(resp[0]), .HREADRam(rdat[0]));

  ahb_latency_ram #(.RAM_LATENCY(3), .BURST_EN(1'b1)) u_lat3 (
    .HCLK(clk), .HRESETn(rst_n), .HSELRam(sel[1]), .HADDR(haddr), .HWRITE(hwrite),
    .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HREADY(hready), .HWDATA(hwdata),
    .HWSTRB(hwstrb), .HREADYRam(rdy[1]), .HRESPRam(resp[1]), .HREADRam(rdat[1]));

  ahb_latency_ram #(.RAM_LATENCY(3), .BURST_EN(1'b0)) u_lat3nb (
    .HCLK(clk), .HRESETn(rst_n), .HSELRam(sel[2]), .HADDR(haddr), .HWRITE(hwrite),
    .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HREADY(hready), .HWDATA(hwdata),
    .HWSTRB(hwstrb), .HREADYRam(rdy[2]), .HRESPRam(resp[2]), .HREADRam(rdat[2]));

  function automatic int lat_of(input int inst);
    return (inst == 0) ? 0 : 3;
  endfunction

  function automatic bit burst_of(input int inst);
    return inst != 2;
  endfunction

  task automatic set_beat(input int b, input logic [55:0] a, input bit wr, input bit sq,
                          input logic [63:0] d, input logic [7:0] s);
    x_addr[b] = a; x_wr[b] = wr; x_seq[b] = sq; x_wdata[b] = d; x_strb[b] = s;
  endtask

  // Beats complete in order; each write lands before any later beat's data phase.
  task automatic model_run(input int inst, input int n);
    for (int b = 0; b < n; b++) begin
      int w;
      w = int'((x_addr[b] / 56'd8) % 56'(DEPTH));
      e_waits[b] = (lat_of(inst) == 0 || (burst_of(inst) && x_seq[b])) ? 0 : lat_of(inst);
      if (x_wr[b]) begin
        for (int k = 0; k < 8; k++) begin
          if (x_strb[b][k]) begin
            mdl[inst][w][k*8 +: 8] = x_wdata[b][k*8 +: 8];
            mbv[inst][w][k] = 1'b1;
          end
        end
      end
      e_rd[b] = mdl[inst][w];
      for (int k = 0; k < 8; k++) e_mask[b][k*8 +: 8] = mbv[inst][w][k] ? 8'hFF : 8'h00;
    end
  endtask

  // Pipelined AHB master: drives just after posedge, samples on negedge.
  task automatic run_xfers(input int inst, input int n);
    int a = 0;
    int d = -1;
    int cyc = 0;
    cur = inst;
    hburst = (n == 1) ? 3'b000 : (n == 4) ? 3'b011 : 3'b001;
    for (int b = 0; b < 16; b++) begin
      g_waits[b] = 0; g_rd[b] = '0; g_resp[b] = 1'b0; g_errlow[b] = 1'b0;
    end
    while ((a < n || d >= 0) && cyc < 100) begin
      if (a < n) begin
        sel = 3'(1 << inst); haddr = x_addr[a]; hwrite = x_wr[a];
        htrans = x_seq[a] ? HTRANS_SEQ : HTRANS_NONSEQ;
      end else begin
        sel = '0; htrans = HTRANS_IDLE;
      end
      if (d >= 0) begin hwdata = x_wdata[d]; hwstrb = x_strb[d]; end
      @(negedge clk);
      if (d >= 0 && resp[inst]) begin
        if (rdy[inst]) g_resp[d] = 1'b1;
        else g_errlow[d] = 1'b1;
      end
      if (rdy[inst]) begin
        if (d >= 0) g_rd[d] = rdat[inst];
        if (a < n) begin d = a; a++; end
        else d = -1;
      end else if (d >= 0) begin
        g_waits[d]++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    sel = '0; htrans = HTRANS_IDLE;
    n_cmp++;
    if (cyc >= 100) begin
      n_bad++;
      $display("FAIL run_timeout inst=%0d: transfer still open after %0d cycles, required < 100", inst, cyc);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      n_cmp += 3;
      if (rdy[i] !== 1'b1) begin
        n_bad++; $display("FAIL reset_hready inst=%0d: got %b, required 1", i, rdy[i]);
      end
      if (resp[i] !== 1'b0) begin
        n_bad++; $display("FAIL reset_hresp inst=%0d: got %b, required 0", i, resp[i]);
      end
      if (rdat[i] !== 64'h0) begin
        n_bad++; $display("FAIL reset_hread inst=%0d: got %h, required 0", i, rdat[i]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lat0;
    set_beat(0, 56'h10, 1'b1, 1'b0, 64'hDEADBEEF_01234567, 8'hFF);
    set_beat(1, 56'h10, 1'b0, 1'b0, 64'h0, 8'h00);
    run_xfers(0, 2);
    model_run(0, 2);
    n_cmp += 3;
    if (g_waits[0] !== 0 || g_waits[1] !== 0) begin
      n_bad++; $display("FAIL lat0_waits: got %0d/%0d, required 0/0", g_waits[0], g_waits[1]);
    end
    if (g_rd[1] !== 64'hDEADBEEF_01234567) begin
      n_bad++; $display("FAIL lat0_rdata: got %h, required deadbeef01234567", g_rd[1]);
    end
    if (g_resp[0] | g_resp[1]) begin
      n_bad++; $display("FAIL lat0_resp: got ERROR, required OKAY");
    end
  endtask

  task automatic test_lat3_single;
    set_beat(0, 56'h20, 1'b1, 1'b0, 64'h1122_3344_5566_7788, 8'hFF);
    set_beat(1, 56'h20, 1'b0, 1'b0, 64'h0, 8'h00);
    run_xfers(1, 2);
    model_run(1, 2);
    n_cmp += 2;
    if (g_waits[1] !== 3) begin
      n_bad++; $display("FAIL lat3_read_waits: got %0d, required 3", g_waits[1]);
    end
    if (g_rd[1] !== 64'h1122_3344_5566_7788) begin
      n_bad++; $display("FAIL lat3_read_data: got %h, required 1122334455667788", g_rd[1]);
    end
  endtask

  task automatic test_burst;
    for (int inst = 1; inst <= 2; inst++) begin
      for (int b = 0; b < 4; b++)
        set_beat(b, 56'h40 + 56'(b*8), 1'b1, b != 0, 64'hA5A5_0000_0000_0000 + 64'(inst*16 + b), 8'hFF);
      run_xfers(inst, 4);
      model_run(inst, 4);
      for (int b = 0; b < 4; b++) set_beat(b, 56'h40 + 56'(b*8), 1'b0, b != 0, 64'h0, 8'h00);
      run_xfers(inst, 4);
      model_run(inst, 4);
      for (int b = 0; b < 4; b++) begin
        int want;
        want = (inst == 2 || b == 0) ? 3 : 0;
        n_cmp += 2;
        if (g_waits[b] !== want) begin
          n_bad++; $display("FAIL burst_waits inst=%0d beat=%0d: got %0d, required %0d", inst, b, g_waits[b], want);
        end
        if (g_rd[b] !== 64'hA5A5_0000_0000_0000 + 64'(inst*16 + b)) begin
          n_bad++; $display("FAIL burst_data inst=%0d beat=%0d: got %h", inst, b, g_rd[b]);
        end
      end
    end
  endtask

  task automatic test_strobes;
    set_beat(0, 56'h100, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    set_beat(1, 56'h100, 1'b1, 1'b0, 64'h0, 8'h0F);
    set_beat(2, 56'h100, 1'b0, 1'b0, 64'h0, 8'h00);
    run_xfers(0, 3);
    model_run(0, 3);
    n_cmp++;
    if (g_rd[2] !== 64'hFFFF_FFFF_0000_0000) begin
      n_bad++; $display("FAIL strobe_data: got %h, required ffffffff00000000", g_rd[2]);
    end
  endtask

  task automatic test_reset_midwrite;
    set_beat(0, 56'h80, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 8'hFF);
    run_xfers(1, 1);
    model_run(1, 1);
    cur = 1;
    sel = 3'b010; haddr = 56'h80; hwrite = 1'b1; htrans = HTRANS_NONSEQ;
    @(posedge clk); #1;
    sel = '0; htrans = HTRANS_IDLE; hwdata = 64'hBAD0_BAD0_BAD0_BAD0; hwstrb = 8'hFF;
    @(posedge clk); #1;
    n_cmp += 2;
    if (rdy[1] !== 1'b0) begin
      n_bad++; $display("FAIL midwrite_stalled: got hready %b, required 0", rdy[1]);
    end
    #2 rst_n = 1'b0;
    #1;
    if (rdy[1] !== 1'b1) begin
      n_bad++; $display("FAIL midwrite_reset_hready: got %b, required 1", rdy[1]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_beat(0, 56'h80, 1'b0, 1'b0, 64'h0, 8'h00);
    run_xfers(1, 1);
    n_cmp++;
    if (g_rd[0] !== 64'h0123_4567_89AB_CDEF) begin
      n_bad++; $display("FAIL midwrite_old_data: got %h, required 0123456789abcdef", g_rd[0]);
    end
  endtask

`ifdef RAM_ERROR_RESP_EN
  task automatic test_error;
    set_beat(0, 56'h08, 1'b1, 1'b0, 64'h5555_AAAA_5555_AAAA, 8'hFF);
    run_xfers(1, 1);
    model_run(1, 1);
    set_beat(0, 56'h1008, 1'b1, 1'b0, 64'h0, 8'hFF);
    run_xfers(1, 1);
    n_cmp++;
    if (g_waits[0] !== 4 || !g_errlow[0] || !g_resp[0]) begin
      n_bad++; $display("FAIL err_write: waits %0d errlow %0d resp %0d, required 4 1 1", g_waits[0], g_errlow[0], g_resp[0]);
    end
    set_beat(0, 56'h1007, 1'b0, 1'b0, 64'h0, 8'h00);
    run_xfers(1, 1);
    n_cmp++;
    if (g_waits[0] !== 4 || !g_errlow[0] || !g_resp[0]) begin
      n_bad++; $display("FAIL err_read: waits %0d errlow %0d resp %0d, required 4 1 1", g_waits[0], g_errlow[0], g_resp[0]);
    end
    set_beat(0, 56'h08, 1'b0, 1'b0, 64'h0, 8'h00);
    run_xfers(1, 1);
    n_cmp++;
    if (g_rd[0] !== 64'h5555_AAAA_5555_AAAA) begin
      n_bad++; $display("FAIL err_mem_untouched: got %h, required 5555aaaa5555aaaa", g_rd[0]);
    end
  endtask
`else
  task automatic test_alias;
    set_beat(0, 56'h1018, 1'b1, 1'b0, 64'hCAFE_F00D_1234_5678, 8'hFF);
    set_beat(1, 56'h18, 1'b0, 1'b0, 64'h0, 8'h00);
    run_xfers(1, 2);
    model_run(1, 2);
    n_cmp += 2;
    if (g_rd[1] !== 64'hCAFE_F00D_1234_5678) begin
      n_bad++; $display("FAIL alias_data: got %h, required cafef00d12345678", g_rd[1]);
    end
    if (g_resp[0] | g_errlow[0]) begin
      n_bad++; $display("FAIL alias_resp: got ERROR, required OKAY");
    end
  endtask
`endif

  task automatic test_random;
    for (int t = 0; t < 40; t++) begin
      int inst, n, base;
      inst = $urandom_range(0, NI-1);
      n    = $urandom_range(1, 4);
      base = $urandom_range(0, DEPTH-5);
      for (int b = 0; b < n; b++)
        set_beat(b, 56'((base + b) * 8), 1'($urandom_range(0, 1)), b != 0,
                 {$urandom, $urandom}, 8'($urandom));
      run_xfers(inst, n);
      model_run(inst, n);
      for (int b = 0; b < n; b++) begin
        n_cmp += 2;
        if (g_waits[b] !== e_waits[b] || g_resp[b] || g_errlow[b]) begin
          n_bad++; $display("FAIL rand_timing t=%0d inst=%0d beat=%0d: waits %0d resp %0d, required %0d OKAY",
                            t, inst, b, g_waits[b], g_resp[b] | g_errlow[b], e_waits[b]);
        end
        if (!x_wr[b] && ((g_rd[b] & e_mask[b]) !== (e_rd[b] & e_mask[b]))) begin
          n_bad++; $display("FAIL rand_rdata t=%0d inst=%0d beat=%0d: got %h, required %h (mask %h)",
                            t, inst, b, g_rd[b], e_rd[b], e_mask[b]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; sel = '0; haddr = '0; hwrite = 1'b0; htrans = HTRANS_IDLE;
    hsize = 3'b011; hburst = 3'b000; hwdata = '0; hwstrb = '0;
    for (int i = 0; i < NI; i++)
      for (int w = 0; w < DEPTH; w++) mbv[i][w] = 8'h00;
    test_reset();
    test_lat0();
    test_lat3_single();
    test_burst();
    test_strobes();
    test_reset_midwrite();
`ifdef RAM_ERROR_RESP_EN
    test_error();
`else
    test_alias();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded 500000 time units");
    $fatal(1, "timeout");
  end

endmodule
